// File: rtl/interfaz_tx.sv
// Transmit bridge: captures an ALU result on the rising edge of i_result_valid and
// streams it to the UART TX as TRAMA_SIZE-bit frames, lowest frame first.
module interfaz_tx #(
    parameter int unsigned DATA_SIZE      = 8,
    parameter int unsigned TRAMA_SIZE     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_result_valid,
    input  logic [DATA_SIZE-1:0]  i_alu_result,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [TRAMA_SIZE-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_sent,
    output logic                  o_overrun,
    output logic                  o_timeout
);
    localparam int unsigned NUM_FRAMES = (DATA_SIZE + TRAMA_SIZE - 1) / TRAMA_SIZE;
    localparam int unsigned SH_W       = NUM_FRAMES * TRAMA_SIZE;
    localparam int unsigned FC_W       = $clog2(NUM_FRAMES) + 1;
    localparam int unsigned TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TMO_EN     = (TIMEOUT_CYCLES != 0);

    localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(NUM_FRAMES - 1);
    // Counter value seen in the last WAIT cycle before the timeout fires
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic                    prev_valid_q;
    logic [SH_W-1:0]         shreg_q,    shreg_d;
    logic [FC_W-1:0]         frame_q,    frame_d;
    logic [TMO_W-1:0]        tmo_q,      tmo_d;
    logic                    tx_start_q, tx_start_d;
    logic [TRAMA_SIZE-1:0]   tx_data_q,  tx_data_d;
    logic                    busy_q,     busy_d;
    logic                    sent_q,     sent_d;
    logic                    overrun_q,  overrun_d;
    logic                    timeout_q,  timeout_d;
    logic                    valid_rise;

    assign valid_rise = i_result_valid & ~prev_valid_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        frame_d    = frame_q;
        tmo_d      = tmo_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        sent_d     = 1'b0;
        overrun_d  = overrun_q;
        timeout_d  = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (valid_rise) begin
                    shreg_d = SH_W'(i_alu_result);
                    frame_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_start_d = 1'b1;
                tx_data_d  = shreg_q[TRAMA_SIZE-1:0];
                tmo_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (TMO_EN) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                // A done pulse beats a timeout landing on the same cycle
                if (i_tx_done) begin
                    if (frame_q == LAST_FRAME) begin
                        busy_d  = 1'b0;
                        sent_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d = shreg_q >> TRAMA_SIZE;
                        frame_d = frame_q + FC_W'(1);
                        state_d = ST_START;
                    end
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (valid_rise && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            prev_valid_q <= 1'b0;
            shreg_q      <= '0;
            frame_q      <= '0;
            tmo_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            sent_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= i_result_valid;
            shreg_q      <= shreg_d;
            frame_q      <= frame_d;
            tmo_q        <= tmo_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            sent_q       <= sent_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;
    assign o_sent     = sent_q;
    assign o_overrun  = overrun_q;
    assign o_timeout  = timeout_q;

endmodule
